dmem_arbiter: RTL and testbench

Shares the single-port data SRAM macro (S013LLLPSP_X256Y8D8 class: active-low CEN/WEN, clocked on inverted cp2) between the AVR core data bus and a secondary host port used for program loading, debug and DMA. The block sits between `avr_core` and the macro and replaces the glue decode of `ramadr`/`ramre`/`ramwe`. The CPU has fixed priority. A starvation counter guarantees host progress by stalling the core through `cpuwait`.

---
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data SRAM between the AVR core (fixed priority)
// and a host port; a starvation counter forces a host slot by stalling the core.
module dmem_arbiter #(
  parameter int DATA_BASE  = 256,
  parameter int MEM_AW     = 11,
  parameter int STARVE_MAX = 8
) (
  input  logic              cp2,
  input  logic              ireset,
  input  logic [11:0]       cpu_ramadr,
  input  logic              cpu_ramre,
  input  logic              cpu_ramwe,
  input  logic [7:0]        cpu_dbusout,
  output logic [7:0]        cpu_dbusin,
  output logic              cpuwait,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [MEM_AW-1:0] host_adr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic              host_rvalid,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [MEM_AW-1:0] mem_a,
  output logic [7:0]        mem_d,
  input  logic [7:0]        mem_q
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FORCE = 1'b1
  } state_t;

  localparam logic [31:0] C_BASE     = 32'(DATA_BASE);
  localparam logic [31:0] C_END      = 32'(DATA_BASE + (1 << MEM_AW));
  localparam logic [7:0]  C_CNT_TOP  = 8'(STARVE_MAX - 1);

  state_t            r_state;
  logic [7:0]        r_starve_cnt;
  logic [7:0]        r_host_rdata;
  logic              r_host_rvalid;

  logic [31:0]       w_adr_ext;
  logic              w_cpu_hit;
  logic [MEM_AW-1:0] w_cpu_a;
  logic              w_own_cpu;
  logic              w_own_host;
  logic              w_host_rd;

  assign w_adr_ext = 32'(cpu_ramadr);
  assign w_cpu_hit = (cpu_ramre | cpu_ramwe) & (w_adr_ext >= C_BASE) & (w_adr_ext < C_END);
  assign w_cpu_a   = MEM_AW'(cpu_ramadr - 12'(DATA_BASE));

  // FORCE overrides the core; otherwise the core wins whenever it hits the SRAM window.
  always_comb begin
    w_own_cpu  = 1'b0;
    w_own_host = 1'b0;
    if (r_state == ST_FORCE) begin
      w_own_host = 1'b1;
    end else if (w_cpu_hit) begin
      w_own_cpu = 1'b1;
    end else if (host_req) begin
      w_own_host = 1'b1;
    end
  end

  assign w_host_rd  = w_own_host & ~host_we;

  assign host_ack    = ireset & w_own_host;
  assign cpuwait     = ireset & (r_state == ST_FORCE);
  assign mem_cen     = ~(ireset & (w_own_host | w_own_cpu));
  assign mem_wen     = ~(ireset & ((w_own_host & host_we) | (w_own_cpu & cpu_ramwe)));
  assign mem_a       = w_own_host ? host_adr : w_cpu_a;
  assign mem_d       = w_own_host ? host_wdata : cpu_dbusout;
  assign cpu_dbusin  = mem_q;
  assign host_rdata  = r_host_rdata;
  assign host_rvalid = r_host_rvalid;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      r_state       <= ST_IDLE;
      r_starve_cnt  <= 8'd0;
      r_host_rdata  <= 8'h00;
      r_host_rvalid <= 1'b0;
    end else begin
      r_host_rvalid <= w_host_rd;
      if (w_host_rd) begin
        r_host_rdata <= mem_q;
      end
      case (r_state)
        ST_IDLE: begin
          // Only a denied pending request counts; a grant or a dropped request clears it.
          if (w_cpu_hit && host_req) begin
            if (r_starve_cnt == C_CNT_TOP) begin
              r_state <= ST_FORCE;
            end else begin
              r_starve_cnt <= r_starve_cnt + 8'd1;
            end
          end else begin
            r_starve_cnt <= 8'd0;
          end
        end
        ST_FORCE: begin
          r_state      <= ST_IDLE;
          r_starve_cnt <= 8'd0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_starve_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a negedge-clocked SRAM model behind the macro port.
module tb_dmem_arbiter;

  logic        cp2;
  logic        ireset;
  logic [11:0] cpu_ramadr;
  logic        cpu_ramre;
  logic        cpu_ramwe;
  logic [7:0]  cpu_dbusout;
  logic [7:0]  cpu_dbusin;
  logic        cpuwait;
  logic        host_req;
  logic        host_we;
  logic [10:0] host_adr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_rvalid;
  logic        mem_cen;
  logic        mem_wen;
  logic [10:0] mem_a;
  logic [7:0]  mem_d;
  logic [7:0]  mem_q;

  logic [7:0]  sram [0:2047];

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(
    .DATA_BASE (256),
    .MEM_AW    (11),
    .STARVE_MAX(8)
  ) u_dut (
    .cp2        (cp2),
    .ireset     (ireset),
    .cpu_ramadr (cpu_ramadr),
    .cpu_ramre  (cpu_ramre),
    .cpu_ramwe  (cpu_ramwe),
    .cpu_dbusout(cpu_dbusout),
    .cpu_dbusin (cpu_dbusin),
    .cpuwait    (cpuwait),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_adr   (host_adr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid),
    .mem_cen    (mem_cen),
    .mem_wen    (mem_wen),
    .mem_a      (mem_a),
    .mem_d      (mem_d),
    .mem_q      (mem_q)
  );

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  initial mem_q = 8'h00;
  always @(negedge cp2) begin
    if (!mem_cen) begin
      if (!mem_wen) sram[mem_a] <= mem_d;
      else          mem_q <= sram[mem_a];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge cp2);
    #1;
  endtask

  initial begin
    ireset      = 1'b0;
    cpu_ramadr  = 12'h000;
    cpu_ramre   = 1'b0;
    cpu_ramwe   = 1'b0;
    cpu_dbusout = 8'h00;
    host_req    = 1'b0;
    host_we     = 1'b0;
    host_adr    = 11'h000;
    host_wdata  = 8'h00;

    // reset state, with a host request present to prove the gating
    #2;
    host_req = 1'b1;
    #1;
    chk("rst_cen", 32'(mem_cen), 32'h1);
    chk("rst_wen", 32'(mem_wen), 32'h1);
    chk("rst_cpuwait", 32'(cpuwait), 32'h0);
    chk("rst_ack", 32'(host_ack), 32'h0);
    chk("rst_rvalid", 32'(host_rvalid), 32'h0);
    chk("rst_rdata", 32'(host_rdata), 32'h00);
    host_req = 1'b0;
    @(posedge cp2);
    #3 ireset = 1'b1;

    // CPU write then read at 0x0100
    step;
    cpu_ramadr = 12'h100; cpu_ramwe = 1'b1; cpu_dbusout = 8'hA5;
    #1;
    chk("cpuwr_a", 32'(mem_a), 32'h000);
    chk("cpuwr_wen", 32'(mem_wen), 32'h0);
    chk("cpuwr_cen", 32'(mem_cen), 32'h0);
    chk("cpuwr_d", 32'(mem_d), 32'hA5);
    chk("cpuwr_wait", 32'(cpuwait), 32'h0);
    step;
    cpu_ramwe = 1'b0; cpu_ramre = 1'b1;
    #1;
    chk("cpurd_wen", 32'(mem_wen), 32'h1);
    chk("cpurd_a", 32'(mem_a), 32'h000);
    @(negedge cp2);
    #1;
    chk("cpurd_data", 32'(cpu_dbusin), 32'hA5);
    chk("cpurd_wait", 32'(cpuwait), 32'h0);

    // host write 0x3C to 0x7FF, then read it back
    step;
    cpu_ramre = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_adr = 11'h7FF; host_wdata = 8'h3C;
    #1;
    chk("hwr_ack", 32'(host_ack), 32'h1);
    chk("hwr_a", 32'(mem_a), 32'h7FF);
    chk("hwr_wen", 32'(mem_wen), 32'h0);
    chk("hwr_d", 32'(mem_d), 32'h3C);
    step;
    host_we = 1'b0;
    #1;
    chk("hrd_ack", 32'(host_ack), 32'h1);
    chk("hrd_wen", 32'(mem_wen), 32'h1);
    chk("hwr_no_rvalid", 32'(host_rvalid), 32'h0);
    step;
    host_req = 1'b0;
    #1;
    chk("hrd_rvalid", 32'(host_rvalid), 32'h1);
    chk("hrd_rdata", 32'(host_rdata), 32'h3C);
    chk("hidle_ack", 32'(host_ack), 32'h0);
    chk("hidle_cen", 32'(mem_cen), 32'h1);
    step;
    chk("hrd_rvalid_pulse", 32'(host_rvalid), 32'h0);

    // CPU outside the SRAM window while host requests
    cpu_ramadr = 12'h05F; cpu_ramwe = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_adr = 11'h123;
    #1;
    chk("io_ack", 32'(host_ack), 32'h1);
    chk("io_a", 32'(mem_a), 32'h123);
    chk("io_wen", 32'(mem_wen), 32'h1);
    step;
    cpu_ramadr = 12'h900;
    #1;
    chk("above_ack", 32'(host_ack), 32'h1);
    chk("above_a", 32'(mem_a), 32'h123);
    step;
    cpu_ramadr = 12'h8FF; host_req = 1'b0;
    #1;
    chk("top_a", 32'(mem_a), 32'h7FF);
    chk("top_wen", 32'(mem_wen), 32'h0);
    chk("top_ack", 32'(host_ack), 32'h0);
    step;
    cpu_ramwe = 1'b0; cpu_ramadr = 12'h000;

    // continuous CPU traffic: host granted on the 9th cycle via FORCE
    step;
    cpu_ramadr = 12'h100; cpu_ramre = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_adr = 11'h005; host_wdata = 8'h77;
    #1;
    chk("starve_c1_ack", 32'(host_ack), 32'h0);
    chk("starve_c1_a", 32'(mem_a), 32'h000);
    for (int i = 2; i <= 8; i++) begin
      step;
      chk($sformatf("starve_c%0d_ack", i), 32'(host_ack), 32'h0);
      chk($sformatf("starve_c%0d_wait", i), 32'(cpuwait), 32'h0);
    end
    step;
    chk("force_ack", 32'(host_ack), 32'h1);
    chk("force_wait", 32'(cpuwait), 32'h1);
    chk("force_a", 32'(mem_a), 32'h005);
    chk("force_wen", 32'(mem_wen), 32'h0);
    host_req = 1'b0;
    step;
    chk("retry_wait", 32'(cpuwait), 32'h0);
    chk("retry_ack", 32'(host_ack), 32'h0);
    chk("retry_a", 32'(mem_a), 32'h000);
    chk("retry_cen", 32'(mem_cen), 32'h0);

    // partial starvation (5 cycles), drop, then a full 8 denied cycles again
    step;
    host_req = 1'b1;
    #1;
    chk("part_c1_ack", 32'(host_ack), 32'h0);
    for (int i = 2; i <= 5; i++) begin
      step;
      chk($sformatf("part_c%0d_ack", i), 32'(host_ack), 32'h0);
    end
    step;
    host_req = 1'b0;
    #1;
    chk("drop_ack", 32'(host_ack), 32'h0);
    step;
    host_req = 1'b1;
    #1;
    chk("again_c1_ack", 32'(host_ack), 32'h0);
    for (int i = 2; i <= 8; i++) begin
      step;
      chk($sformatf("again_c%0d_ack", i), 32'(host_ack), 32'h0);
    end
    step;
    chk("again_force_ack", 32'(host_ack), 32'h1);
    chk("again_force_wait", 32'(cpuwait), 32'h1);
    host_req = 1'b0;

    // reset asserted during FORCE (host read slot)
    step;
    host_req = 1'b1; host_we = 1'b0; host_adr = 11'h005;
    for (int i = 2; i <= 8; i++) step;
    step;
    chk("rf_pre_wait", 32'(cpuwait), 32'h1);
    chk("rf_pre_ack", 32'(host_ack), 32'h1);
    #1 ireset = 1'b0;
    #1;
    chk("rf_wait", 32'(cpuwait), 32'h0);
    chk("rf_ack", 32'(host_ack), 32'h0);
    chk("rf_cen", 32'(mem_cen), 32'h1);
    chk("rf_wen", 32'(mem_wen), 32'h1);
    @(posedge cp2);
    #1;
    chk("rf_rvalid", 32'(host_rvalid), 32'h0);
    #2 ireset = 1'b1;
    step;
    chk("rf_idle_wait", 32'(cpuwait), 32'h0);
    chk("rf_idle_ack", 32'(host_ack), 32'h0);
    chk("rf_idle_cen", 32'(mem_cen), 32'h0);
    chk("rf_idle_a", 32'(mem_a), 32'h000);

    host_req = 1'b0; cpu_ramre = 1'b0;
    step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
